// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

    localparam int         RAM_AW  = 14;
    localparam logic [3:0] BE_FULL = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        DM_RD,
        RMW_RD,
        DM_WR
    } arb_state_t;

endpackage

// File: rtl/mem_byte_merge.sv
// rtl/mem_byte_merge.sv - per-byte-lane merge of store data over a RAM word
module mem_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  byte_en,
    output logic [31:0] merged
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = byte_en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one single-port synchronous RAM
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [3:0]        dm_byte_en,
    output logic [31:0]       dm_rdata,
    output logic              dm_done,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              mem_stall,
    output logic              if_stall
);

    arb_state_t        state;
    logic              fair;
    logic [RAM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged;
    logic              grant_if;
    logic              grant_wr;
    logic              grant_rd;
    logic [RAM_AW-1:0] if_word;
    logic [RAM_AW-1:0] dm_word;
    logic              unused_addr_bits;

    assign if_word = if_addr[RAM_AW+1:2];
    assign dm_word = dm_addr[RAM_AW+1:2];
    assign unused_addr_bits = ^{if_addr[31:RAM_AW+2], if_addr[1:0],
                                dm_addr[31:RAM_AW+2], dm_addr[1:0]};

    // A write outranks a read, so read+write together is handled as a store.
    always_comb begin
        grant_if = 1'b0;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE) begin
            if (fair && if_req)  grant_if = 1'b1;
            else if (dm_write)   grant_wr = 1'b1;
            else if (dm_read)    grant_rd = 1'b1;
            else if (if_req)     grant_if = 1'b1;
        end
    end

    always_comb begin
        ram_addr = addr_q;
        if (grant_if)                  ram_addr = if_word;
        else if (grant_wr || grant_rd) ram_addr = dm_word;
    end

    mem_byte_merge u_merge (
        .old_word (ram_rdata),
        .new_word (dm_wdata),
        .byte_en  (dm_byte_en),
        .merged   (merged)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            fair    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        addr_q <= if_word;
                        state  <= IF_RD;
                    end else if (grant_wr) begin
                        addr_q  <= dm_word;
                        wdata_q <= dm_wdata;
                        state   <= (dm_byte_en == BE_FULL) ? DM_WR : RMW_RD;
                    end else if (grant_rd) begin
                        addr_q <= dm_word;
                        state  <= DM_RD;
                    end
                end
                IF_RD: begin
                    fair  <= 1'b0;
                    state <= IDLE;
                end
                DM_RD: begin
                    fair  <= 1'b1;
                    state <= IDLE;
                end
                RMW_RD: begin
                    wdata_q <= merged;
                    state   <= DM_WR;
                end
                DM_WR: begin
                    fair  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_valid  = (state == IF_RD);
    assign dm_done   = (state == DM_RD) || (state == DM_WR);
    assign if_rdata  = if_valid ? ram_rdata : '0;
    assign dm_rdata  = (state == DM_RD) ? ram_rdata : '0;
    assign ram_we    = (state == DM_WR);
    assign ram_wdata = wdata_q;
    assign mem_stall = (dm_read || dm_write) && !dm_done;
    assign if_stall  = if_req && !if_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;

    localparam int RAM_WORDS = 16384;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byte_en;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        mem_stall;
    logic        if_stall;

    mem_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .dm_read    (dm_read),
        .dm_write   (dm_write),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_byte_en (dm_byte_en),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .mem_stall  (mem_stall),
        .if_stall   (if_stall)
    );

    typedef struct {
        logic        is_load;
        logic [31:0] data;
    } dm_exp_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem [RAM_WORDS];
    logic [31:0] ram     [RAM_WORDS];
    logic        pre_init;
    logic [31:0] if_q [$];
    dm_exp_t     dm_q [$];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port synchronous RAM: read data appears one cycle after the address.
    always @(posedge clock) begin
        if (pre_init) begin
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= init_word(i);
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        dm_exp_t e;
        logic [31:0] ei;
        if (if_valid && dm_done) chk("valid_and_done_overlap", 32'd1, 32'd0);
        if (ram_we) chk("ram_we_only_with_done", 32'(dm_done), 32'd1);
        if (if_valid) begin
            if (if_q.size() == 0) begin
                chk("if_valid_unexpected", 32'd1, 32'd0);
            end else begin
                ei = if_q.pop_front();
                chk("if_rdata", if_rdata, ei);
            end
        end
        if (dm_done) begin
            if (dm_q.size() == 0) begin
                chk("dm_done_unexpected", 32'd1, 32'd0);
            end else begin
                e = dm_q.pop_front();
                if (e.is_load) chk("dm_rdata", dm_rdata, e.data);
            end
        end
    end

    task automatic do_dm(input bit settle, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                         output int lat, output int stalls, output int wes,
                         output logic [31:0] rdata);
        logic [13:0] w;
        dm_exp_t     e;
        if (settle) @(negedge clock);
        w = addr[15:2];
        e.is_load = rd && !wr;
        e.data    = ref_mem[w];
        dm_q.push_back(e);
        if (wr) ref_mem[w] = merge_ref(ref_mem[w], wd, be);
        dm_read = rd; dm_write = wr; dm_addr = addr; dm_wdata = wd; dm_byte_en = be;
        lat = 0; stalls = 0; wes = 0; rdata = '0;
        #1;
        if (mem_stall) stalls++;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            lat++;
            if (mem_stall) stalls++;
            if (ram_we) wes++;
            if (dm_done) break;
        end
        if (!dm_done) chk("dm_done_timeout", 32'd0, 32'd1);
        rdata = dm_rdata;
        dm_read = 1'b0;
        dm_write = 1'b0;
    endtask

    task automatic do_if(input bit settle, input logic [31:0] addr,
                         output int lat, output int stalls);
        if (settle) @(negedge clock);
        if_q.push_back(ref_mem[addr[15:2]]);
        if_req = 1'b1; if_addr = addr;
        lat = 0; stalls = 0;
        #1;
        if (if_stall) stalls++;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            lat++;
            if (if_stall) stalls++;
            if (if_valid) break;
        end
        if (!if_valid) chk("if_valid_timeout", 32'd0, 32'd1);
        if_req = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat, st, wes, nd, ni, first_if;
        logic [31:0] rd;
        logic [7:0]  seq;

        reset = 1'b1; pre_init = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0; dm_byte_en = '0;
        for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = init_word(i);
        @(negedge clock);
        pre_init = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        chk("reset_if_valid", 32'(if_valid), 32'd0);
        chk("reset_dm_done", 32'(dm_done), 32'd0);
        chk("reset_mem_stall", 32'(mem_stall), 32'd0);
        chk("reset_if_stall", 32'(if_stall), 32'd0);

        do_dm(1, 0, 1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, lat, st, wes, rd);
        chk("full_store_latency", lat, 1);
        chk("full_store_we_cycles", wes, 1);
        do_dm(1, 1, 0, 32'h0000_0040, 32'h0, 4'b0000, lat, st, wes, rd);
        chk("load_latency", lat, 1);
        chk("load_stall_cycles", st, 1);
        chk("load_data", rd, 32'hDEAD_BEEF);

        do_dm(1, 0, 1, 32'h0000_0040, 32'h1122_3344, 4'b1111, lat, st, wes, rd);
        do_dm(1, 0, 1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0101, lat, st, wes, rd);
        chk("partial_store_latency", lat, 2);
        chk("partial_store_we_cycles", wes, 1);
        do_dm(1, 1, 0, 32'h0000_0040, 32'h0, 4'b0000, lat, st, wes, rd);
        chk("partial_store_result", rd, 32'h11BB_33DD);

        do_dm(1, 0, 1, 32'hFFFF_0082, 32'h0102_0304, 4'b1111, lat, st, wes, rd);
        chk("full_store2_latency", lat, 1);
        do_dm(1, 0, 1, 32'h0000_0080, 32'hFFFF_FFFF, 4'b0000, lat, st, wes, rd);
        chk("empty_be_latency", lat, 2);
        do_dm(1, 1, 0, 32'h0000_0080, 32'h0, 4'b0000, lat, st, wes, rd);
        chk("empty_be_unchanged", rd, 32'h0102_0304);
        do_dm(1, 1, 1, 32'h0000_0080, 32'hFFFF_FFFF, 4'b1000, lat, st, wes, rd);
        chk("read_write_is_store", 32'(wes), 32'd1);
        do_dm(1, 1, 0, 32'h0000_0080, 32'h0, 4'b0000, lat, st, wes, rd);
        chk("read_write_result", rd, 32'hFF02_0304);

        do_if(1, 32'h0000_0400, lat, st);
        chk("fetch_latency", lat, 1);
        chk("fetch_stall_cycles", st, 1);

        // Fetch and load requested together and held: completions must alternate.
        @(negedge clock);
        if_q.push_back(ref_mem[14'h101]);
        if_q.push_back(ref_mem[14'h101]);
        for (int k = 0; k < 2; k++) begin
            dm_exp_t e;
            e.is_load = 1'b1;
            e.data    = ref_mem[14'h10];
            dm_q.push_back(e);
        end
        if_req = 1'b1; if_addr = 32'h0000_0404; dm_read = 1'b1; dm_addr = 32'h0000_0040;
        nd = 0; ni = 0; first_if = 0; seq = '0;
        for (int c = 1; c <= 20 && (nd < 2 || ni < 2); c++) begin
            @(negedge clock);
            if (dm_done) begin
                seq = {seq[5:0], 2'b01};
                nd++;
                if (nd == 2) dm_read = 1'b0;
            end
            if (if_valid) begin
                seq = {seq[5:0], 2'b10};
                ni++;
                if (first_if == 0) first_if = c;
                if (ni == 2) if_req = 1'b0;
            end
        end
        dm_read = 1'b0; if_req = 1'b0;
        chk("contention_order", 32'(seq), 32'h0000_0066);
        chk("contention_fetch_within_4", 32'(first_if >= 1 && first_if <= 4), 32'd1);

        // Reset while the partial store is in its read-modify phase.
        @(negedge clock);
        @(negedge clock);
        dm_write = 1'b1; dm_addr = 32'h0000_0040; dm_wdata = 32'hCAFE_F00D; dm_byte_en = 4'b0011;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        dm_write = 1'b0;
        reset = 1'b0;
        chk("abort_no_done", 32'(dm_done), 32'd0);
        chk("abort_no_we", 32'(ram_we), 32'd0);
        do_dm(0, 1, 0, 32'h0000_0040, 32'h0, 4'b0000, lat, st, wes, rd);
        chk("abort_idle_after_reset", lat, 1);
        chk("abort_ram_unchanged", rd, 32'h11BB_33DD);

        fork
            begin : fetch_driver
                int fl, fs;
                for (int n = 0; n < 40; n++) begin
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    a = ($urandom & 32'hFFFF_0003) | (32'(14'h100 + 14'($urandom_range(0, 255))) << 2);
                    do_if(0, a, fl, fs);
                end
            end
            begin : data_driver
                int dl, ds, dw;
                logic [31:0] dr;
                for (int n = 0; n < 60; n++) begin
                    logic [31:0] a;
                    int          kind;
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    a = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 63)) << 2);
                    kind = $urandom_range(0, 3);
                    case (kind)
                        0:       do_dm(0, 1, 0, a, $urandom, 4'($urandom), dl, ds, dw, dr);
                        1:       do_dm(0, 0, 1, a, $urandom, 4'($urandom), dl, ds, dw, dr);
                        2:       do_dm(0, 0, 1, a, $urandom, 4'b1111, dl, ds, dw, dr);
                        default: do_dm(0, 1, 1, a, $urandom, 4'($urandom), dl, ds, dw, dr);
                    endcase
                end
            end
        join

        for (int w = 0; w < 64; w++) do_dm(0, 1, 0, 32'(w) << 2, 32'h0, 4'b0000, lat, st, wes, rd);
        repeat (3) @(negedge clock);
        chk("if_queue_drained", 32'(if_q.size()), 32'd0);
        chk("dm_queue_drained", 32'(dm_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
